// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus width defaults,
// FSM state encodings and master index constants.
package cpu_defs;
  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  localparam int M_CPU = 0;
  localparam int M_LDR = 1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone eligible master wins,
// a tie goes to the master that did not win last time.
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       w,
  output logic       any
);
  always_comb begin
    any = |elig;
    if (elig == 2'b11) w = ~last;
    else               w = elig[1];
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a shared memory bus; each granted access holds the
// memory strobe for MEM_LAT cycles, then pulses done to its owner.
module mem_bus_arbiter
  import cpu_defs::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;

  logic [1:0] elig;
  logic       win;
  logic       any_elig;
  logic       win_ldr;

  // A master that is seeing its done pulse is not regranted in that cycle.
  assign elig[M_CPU] = req[M_CPU] & ~halt & ~done_q[M_CPU];
  assign elig[M_LDR] = req[M_LDR] & ~done_q[M_LDR];
  assign win_ldr     = (win == 1'(M_LDR));

  rr_pick2 u_pick (
    .elig (elig),
    .last (last_q),
    .w    (win),
    .any  (any_elig)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (any_elig) state_d = ARB_ACCESS;
      ARB_ACCESS: if (cnt_q == 4'd0) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    rdata_d     = rdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    case (state_q)
      ARB_IDLE: begin
        gnt_d    = 2'b00;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if (any_elig) begin
          gnt_d[win]  = 1'b1;
          last_d      = win;
          cnt_d       = CNT_LOAD;
          mem_addr_d  = win_ldr ? addr1 : addr0;
          mem_wdata_d = win_ldr ? wdata1 : wdata0;
          mem_wr_d    = we[win];
          mem_rd_d    = ~we[win];
        end
      end
      ARB_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (mem_rd_q) rdata_d = mem_rdata;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          gnt_d    = 2'b00;
          done_d   = gnt_q;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: MEM_LAT=2 main instance plus a
// MEM_LAT=1 instance; completions are checked against a scoreboard queue.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst1 = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  req = 2'b11;
  logic [1:0]  we = 2'b00;
  logic [12:0] addr0 = 13'h010;
  logic [12:0] addr1 = 13'h020;
  logic [7:0]  wdata0 = 8'h00;
  logic [7:0]  wdata1 = 8'h77;

  logic [1:0]  gnt0, done0, gnt1, done1;
  logic [7:0]  rdata0, rdata1, mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;
  logic        mem_rd0, mem_wr0, mem_rd1, mem_wr1;
  logic [12:0] mem_addr0, mem_addr1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] done;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] model_rdata = 8'h00;

  always #5 clk = ~clk;

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata0 = mem_addr0[7:0] ^ 8'h99;
  assign mem_rdata1 = mem_addr1[7:0] ^ 8'h99;

  mem_bus_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .halt(halt), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt0), .done(done0), .rdata(rdata0),
    .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_bus_arbiter #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst1), .halt(halt), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt1), .done(done1), .rdata(rdata1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic is_wr, input logic [12:0] a);
    exp_t e;
    if (!is_wr) model_rdata = a[7:0] ^ 8'h99;
    e.done  = (m == 1) ? 2'b10 : 2'b01;
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endtask

  // Completion monitor for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (gnt0 != 2'b00) chk("gnt_both", {31'd0, gnt0 == 2'b11}, 32'd0);
      if (done0 != 2'b00) begin
        $display("txn: done=%b rdata=%02h", done0, rdata0);
        if (exp_q.size() == 0) chk("sb_unexpected_done", {30'd0, done0}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_done_owner", {30'd0, done0}, {30'd0, e.done});
          chk("sb_rdata", {24'd0, rdata0}, {24'd0, e.rdata});
        end
      end
    end
  end

  initial begin
    logic [1:0] exp_g;
    // 1: reset with both requesting
    tick(); tick();
    chk("rst_gnt", {30'd0, gnt0}, 32'd0);
    chk("rst_done", {30'd0, done0}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd0, mem_wr0}, 32'd0);
    chk("rst_addr", {19'd0, mem_addr0}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata0}, 32'd0);
    chk("rst_rdata", {24'd0, rdata0}, 32'd0);
    rst = 1'b1;
    push(0, 1'b0, 13'h010);
    tick();
    chk("first_gnt_m0", {30'd0, gnt0}, 32'd1);
    req = 2'b00;
    tick(); tick();
    chk("first_done", {30'd0, done0}, 32'd1);
    tick();

    // 2: single M0 read
    req = 2'b01; we = 2'b00; addr0 = 13'h0A5;
    push(0, 1'b0, 13'h0A5);
    tick();
    chk("rd_gnt", {30'd0, gnt0}, 32'd1);
    chk("rd_strobe_e0", {31'd0, mem_rd0}, 32'd1);
    chk("rd_addr", {19'd0, mem_addr0}, 32'h0A5);
    req = 2'b00; addr0 = 13'h000;
    tick();
    chk("rd_strobe_e1", {31'd0, mem_rd0}, 32'd1);
    chk("rd_done_early", {30'd0, done0}, 32'd0);
    tick();
    chk("rd_strobe_off", {31'd0, mem_rd0}, 32'd0);
    chk("rd_done", {30'd0, done0}, 32'd1);
    chk("rd_rdata", {24'd0, rdata0}, 32'h3C);
    tick();
    chk("rd_done_1cyc", {30'd0, done0}, 32'd0);

    // 3: single M1 write
    req = 2'b10; we = 2'b10; addr1 = 13'h1FFF; wdata1 = 8'hFF;
    push(1, 1'b1, 13'h1FFF);
    tick();
    chk("wr_gnt", {30'd0, gnt0}, 32'd2);
    chk("wr_strobes", {30'd0, mem_rd0, mem_wr0}, 32'd1);
    chk("wr_addr", {19'd0, mem_addr0}, 32'h1FFF);
    chk("wr_wdata", {24'd0, mem_wdata0}, 32'hFF);
    req = 2'b00;
    tick();
    chk("wr_strobe_e1", {31'd0, mem_wr0}, 32'd1);
    tick();
    chk("wr_strobe_off", {31'd0, mem_wr0}, 32'd0);
    chk("wr_done", {30'd0, done0}, 32'd2);
    chk("wr_rdata_kept", {24'd0, rdata0}, 32'h3C);
    tick();

    // 4: contention, strict alternation starting with M0
    req = 2'b11; we = 2'b00; addr0 = 13'h011; addr1 = 13'h122;
    for (int k = 0; k < 8; k++) push(k % 2, 1'b0, (k % 2 == 1) ? 13'h122 : 13'h011);
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("alt_gnt_%0d", k), {30'd0, gnt0}, {30'd0, exp_g});
      tick(); tick();
      chk($sformatf("alt_bubble_%0d", k), {30'd0, gnt0}, 32'd0);
      chk($sformatf("alt_done_%0d", k), {30'd0, done0}, {30'd0, exp_g});
      if (k == 7) req = 2'b00;
      tick();
    end
    chk("alt_idle", {30'd0, gnt0}, 32'd0);

    // 5: halt masks M0; halt mid-access lets the access finish
    halt = 1'b1; req = 2'b01;
    tick(); tick(); tick(); tick();
    chk("halt_no_gnt", {30'd0, gnt0}, 32'd0);
    halt = 1'b0;
    push(0, 1'b0, 13'h011);
    tick();
    chk("halt_gnt", {30'd0, gnt0}, 32'd1);
    halt = 1'b1;
    tick(); tick();
    chk("halt_done", {30'd0, done0}, 32'd1);
    tick(); tick(); tick();
    chk("halt_masked", {30'd0, gnt0}, 32'd0);
    req = 2'b00; halt = 1'b0;
    tick();

    // 6: reset during an access aborts without a done pulse
    req = 2'b01; addr0 = 13'h033;
    tick();
    chk("abort_gnt", {30'd0, gnt0}, 32'd1);
    rst = 1'b0;
    tick();
    chk("abort_gnt_off", {30'd0, gnt0}, 32'd0);
    chk("abort_strobe_off", {31'd0, mem_rd0}, 32'd0);
    chk("abort_addr", {19'd0, mem_addr0}, 32'd0);
    chk("abort_rdata", {24'd0, rdata0}, 32'd0);
    rst = 1'b1; req = 2'b00;
    tick(); tick();
    chk("abort_no_done", {30'd0, done0}, 32'd0);

    // 6b: MEM_LAT=1 read rerun on the second instance
    rst1 = 1'b1;
    tick();
    req = 2'b01; addr0 = 13'h0A5;
    push(0, 1'b0, 13'h0A5);
    tick();
    chk("l1_gnt", {30'd0, gnt1}, 32'd1);
    chk("l1_strobe", {31'd0, mem_rd1}, 32'd1);
    chk("l1_addr", {19'd0, mem_addr1}, 32'h0A5);
    req = 2'b00;
    tick();
    chk("l1_strobe_off", {31'd0, mem_rd1}, 32'd0);
    chk("l1_done", {30'd0, done1}, 32'd1);
    chk("l1_rdata", {24'd0, rdata1}, 32'h3C);
    chk("l2_still_busy", {31'd0, mem_rd0}, 32'd1);
    tick();
    chk("l1_done_1cyc", {30'd0, done1}, 32'd0);
    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
